// File: rtl/rpm_meter.sv
// Hall-sensor RPM meter: synchronises the hall lines, classifies each step as CW/CCW/illegal
// and reports mechanical RPM and direction once per fixed measurement window.
package rpm_meter_pkg;
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_CW    = 2'd1,
    DIR_CCW   = 2'd2,
    DIR_BRAKE = 2'd3
  } rotation_direction_t;
endpackage

module rpm_meter
  import rpm_meter_pkg::*;
#(
  parameter int unsigned clk_freq_hz        = 27_000_000,
  parameter int unsigned pole_pairs         = 1,
  parameter int unsigned rpm_counter_width  = 12,
  parameter int unsigned rpm_measurement_ms = 100
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [2:0]                   hall,
  output logic [rpm_counter_width-1:0] rpm,
  output rotation_direction_t          direction,
  output logic                         rpm_valid,
  output logic                         hall_error
);

  localparam int unsigned WINDOW_TICKS = clk_freq_hz / 1000 * rpm_measurement_ms;
  // Edge count seen in one window at exactly 60_000 RPM.
  localparam int unsigned EDGES_AT_MAX = 6 * pole_pairs * rpm_measurement_ms;
  localparam int unsigned SAFE_EDGES   = (EDGES_AT_MAX == 0) ? 1 : EDGES_AT_MAX;
  localparam int unsigned RPM_SCALE    = 60_000 / SAFE_EDGES;
  localparam bit          SCALE_OK     = (EDGES_AT_MAX != 0) && ((60_000 % SAFE_EDGES) == 0)
                                         && (RPM_SCALE >= 1) && (WINDOW_TICKS >= 1);

  localparam int unsigned TICK_W  = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int unsigned EDGE_W  = (EDGES_AT_MAX > 0) ? $clog2(EDGES_AT_MAX + 1) : 1;
  localparam int unsigned SCALE_W = $clog2(RPM_SCALE + 1);
  localparam int unsigned PROD_W  = EDGE_W + SCALE_W;
  localparam int unsigned CMP_W   = ((PROD_W > rpm_counter_width) ? PROD_W : rpm_counter_width) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;
  localparam logic [CMP_W-1:0]  RPM_MAX   = {{(CMP_W - rpm_counter_width){1'b0}},
                                             {rpm_counter_width{1'b1}}};

  if (!SCALE_OK) begin : g_bad_scale
    $error("rpm_meter: 60000/(6*pole_pairs*rpm_measurement_ms) must be an integer >= 1");
  end

  // Position along the forward sequence 1-3-2-6-4-5; 7 marks an illegal code.
  function automatic logic [2:0] hall_pos(input logic [2:0] h);
    case (h)
      3'd1:    return 3'd0;
      3'd3:    return 3'd1;
      3'd2:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd5:    return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] pos_next(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  logic [2:0]                   hall_meta_q, hall_meta_d;
  logic [2:0]                   hall_s_q, hall_s_d;
  logic [2:0]                   hall_prev_q, hall_prev_d;
  logic                         primed_q, primed_d;
  logic                         hall_error_q, hall_error_d;
  logic [TICK_W-1:0]            tick_q, tick_d;
  logic [EDGE_W-1:0]            edges_q, edges_d;
  rotation_direction_t          last_dir_q, last_dir_d;
  logic [rpm_counter_width-1:0] rpm_q, rpm_d;
  rotation_direction_t          direction_q, direction_d;
  logic                         rpm_valid_q, rpm_valid_d;

  logic [2:0]          pos_s, pos_prev;
  logic                hall_change, legal, step_cw, step_ccw;
  logic                valid_step, bad_step, window_end;
  logic [EDGE_W-1:0]   edges_sum;
  rotation_direction_t dir_sum;
  logic [CMP_W-1:0]    product;

  always_comb begin
    hall_meta_d = hall;
    hall_s_d    = hall_meta_q;
    hall_prev_d = hall_s_q;

    pos_s       = hall_pos(hall_s_q);
    pos_prev    = hall_pos(hall_prev_q);
    hall_change = (hall_s_q != hall_prev_q);
    legal       = (pos_s != 3'd7) && (pos_prev != 3'd7);
    step_cw     = legal && (pos_s == pos_next(pos_prev));
    step_ccw    = legal && (pos_prev == pos_next(pos_s));

    // The first change after reset compares against the cleared hall_prev, so it is ignored.
    primed_d     = primed_q | hall_change;
    valid_step   = primed_q && hall_change && (step_cw || step_ccw);
    bad_step     = primed_q && hall_change && !(step_cw || step_ccw);
    hall_error_d = bad_step;

    window_end = (tick_q == TICK_LAST);
    edges_sum  = edges_q;
    dir_sum    = last_dir_q;
    if (valid_step) begin
      edges_sum = (edges_q == EDGE_MAX) ? edges_q : edges_q + EDGE_W'(1);
      dir_sum   = step_cw ? DIR_CW : DIR_CCW;
    end
    product = CMP_W'(edges_sum) * CMP_W'(RPM_SCALE);

    tick_d      = tick_q;
    edges_d     = edges_q;
    last_dir_d  = last_dir_q;
    rpm_d       = rpm_q;
    direction_d = direction_q;
    rpm_valid_d = 1'b0;

    if (!enable) begin
      tick_d      = '0;
      edges_d     = '0;
      last_dir_d  = DIR_NONE;
      rpm_d       = '0;
      direction_d = DIR_NONE;
    end else if (window_end) begin
      // A step arriving on the final cycle is folded into edges_sum before the latch.
      tick_d      = '0;
      edges_d     = '0;
      last_dir_d  = DIR_NONE;
      rpm_d       = (product > RPM_MAX) ? '1 : product[rpm_counter_width-1:0];
      direction_d = (edges_sum == '0) ? DIR_NONE : dir_sum;
      rpm_valid_d = 1'b1;
    end else begin
      tick_d     = tick_q + TICK_W'(1);
      edges_d    = edges_sum;
      last_dir_d = dir_sum;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      hall_meta_q  <= '0;
      hall_s_q     <= '0;
      hall_prev_q  <= '0;
      primed_q     <= 1'b0;
      hall_error_q <= 1'b0;
      tick_q       <= '0;
      edges_q      <= '0;
      last_dir_q   <= DIR_NONE;
      rpm_q        <= '0;
      direction_q  <= DIR_NONE;
      rpm_valid_q  <= 1'b0;
    end else begin
      hall_meta_q  <= hall_meta_d;
      hall_s_q     <= hall_s_d;
      hall_prev_q  <= hall_prev_d;
      primed_q     <= primed_d;
      hall_error_q <= hall_error_d;
      tick_q       <= tick_d;
      edges_q      <= edges_d;
      last_dir_q   <= last_dir_d;
      rpm_q        <= rpm_d;
      direction_q  <= direction_d;
      rpm_valid_q  <= rpm_valid_d;
    end
  end

  assign rpm        = rpm_q;
  assign direction  = direction_q;
  assign rpm_valid  = rpm_valid_q;
  assign hall_error = hall_error_q;

endmodule
